// File: rtl/check_message_generator_if.sv
// ---------------------------------------------------------------------------
// check_message_generator_if
//
// Purpose:
//   Outgoing check-to-variable message stream of the check node processor.
//   A message is transferred on every rising clock edge where msg_valid and
//   msg_ready are both high.
//
// Signals:
//   msg        [DATA_W-1:0]  outgoing message (IEEE-754 single, sign in MSB)
//   msg_idx    [IDX_W-1:0]   edge index the message belongs to
//   msg_valid                msg / msg_idx are valid
//   msg_ready                consumer accepts the current message
//
// Modports:
//   master  - the message generator (drives msg, msg_idx, msg_valid)
//   slave   - the consumer (drives msg_ready)
// ---------------------------------------------------------------------------
interface check_message_generator_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 2
);

  logic [DATA_W-1:0] msg;
  logic [IDX_W-1:0]  msg_idx;
  logic              msg_valid;
  logic              msg_ready;

  modport master (
    output msg,
    output msg_idx,
    output msg_valid,
    input  msg_ready
  );

  modport slave (
    input  msg,
    input  msg_idx,
    input  msg_valid,
    output msg_ready
  );

endinterface

// File: rtl/check_message_generator.sv
// ---------------------------------------------------------------------------
// check_message_generator
//
// Purpose:
//   Output stage of the check node processor. Given the latched absolute
//   minimum, absolute second minimum, the edge position of the minimum and
//   the sign bits of the incoming variable-to-check messages, it serially
//   emits the outgoing check-to-variable messages using the min-sum rule,
//   edge 0 first, over a valid/ready handshake.
//
//   Message for edge k:
//     sign      = (^sign_in) ^ sign_in[k]    (product of the other signs)
//     magnitude = second_min if k == pos, else min
//   Magnitudes are passed bit-exact (no floating-point arithmetic), so
//   NaN / Inf / signed zero travel through unchanged.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   start       in   one-cycle request; samples min/second_min/pos/sign_in
//   min         in   absolute minimum magnitude (sign bit ignored)
//   second_min  in   absolute second minimum magnitude (sign bit ignored)
//   pos         in   edge index of the minimum (3 = no edge matches)
//   sign_in     in   sign bits of incoming messages, bit k = edge k
//   m_if        master side of the message stream (msg, msg_idx,
//               msg_valid out; msg_ready in)
//   busy        out  high while messages are being emitted
//   done        out  one-cycle pulse after the last message is accepted
// ---------------------------------------------------------------------------
module check_message_generator #(
  parameter int DATA_W    = 32,
  parameter int NUM_EDGES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_W-1:0]       min,
  input  logic [DATA_W-1:0]       second_min,
  input  logic [1:0]              pos,
  input  logic [NUM_EDGES-1:0]    sign_in,
  check_message_generator_if.master m_if,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = 2;
  localparam int MAG_W = DATA_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EDGES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State and operand registers
  // -------------------------------------------------------------------------
  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     k_reg, k_next;
  logic [MAG_W-1:0]     min_reg;
  logic [MAG_W-1:0]     smin_reg;
  logic [IDX_W-1:0]     pos_reg;
  logic [NUM_EDGES-1:0] sign_reg;
  logic                 par_reg;
  logic                 load_ops;

  logic                 handshake;
  logic [DATA_W-1:0]    edge_msg [NUM_EDGES];

  // The incoming sign bits of min/second_min are deliberately dropped: the
  // datapath upstream already delivers absolute values and the outgoing sign
  // is rebuilt purely from sign_in.
  logic unused_input_signs;
  assign unused_input_signs = min[DATA_W-1] ^ second_min[DATA_W-1];

  // Operands are captured only when a request is accepted in IDLE, so a
  // start pulse arriving while busy cannot corrupt in-flight messages.
  always_ff @(posedge clk) begin
    if (reset) begin
      min_reg  <= '0;
      smin_reg <= '0;
      pos_reg  <= '0;
      sign_reg <= '0;
      par_reg  <= 1'b0;
    end else if (load_ops) begin
      min_reg  <= min[MAG_W-1:0];
      smin_reg <= second_min[MAG_W-1:0];
      pos_reg  <= pos;
      sign_reg <= sign_in;
      par_reg  <= ^sign_in;
    end
  end

  // -------------------------------------------------------------------------
  // Per-edge message construction from the latched operands.
  // Excluding an edge's own sign from the product is the same as XOR-ing it
  // back into the full parity. pos_reg == 3 never matches any edge, so every
  // edge gets the minimum magnitude in that case.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_EDGES; gi++) begin : g_edge
    assign edge_msg[gi] = {par_reg ^ sign_reg[gi],
                           (pos_reg == IDX_W'(gi)) ? smin_reg : min_reg};
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and outputs
  // -------------------------------------------------------------------------
  assign handshake = m_if.msg_valid && m_if.msg_ready;

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    load_ops   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          load_ops   = 1'b1;
          k_next     = '0;
          state_next = EMIT;
        end
      end

      EMIT: begin
        busy = 1'b1;
        if (handshake) begin
          if (k_reg == LAST_IDX) begin
            // Counter returns to 0 so msg_idx reads 0 outside EMIT.
            k_next     = '0;
            state_next = DONE;
          end else begin
            k_next = k_reg + 1'b1;
          end
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        k_next     = '0;
      end
    endcase
  end

  // The message is a mux of registered values selected by the registered
  // counter, so it is glitch-free and holds steady under backpressure.
  // Outside EMIT the bus is forced to zero.
  always_comb begin
    m_if.msg_valid = 1'b0;
    m_if.msg_idx   = '0;
    m_if.msg       = '0;
    if (state_reg == EMIT) begin
      m_if.msg_valid = 1'b1;
      m_if.msg_idx   = k_reg;
      m_if.msg       = edge_msg[k_reg];
    end
  end

endmodule

// File: tb/tb_check_message_generator.sv
// ---------------------------------------------------------------------------
// tb_check_message_generator
//
// Directed bench for check_message_generator. Inputs are driven 1 ns after
// each rising edge and outputs are checked at that same point, well away
// from the next active edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_check_message_generator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] min_v = '0;
  logic [31:0] smin_v = '0;
  logic [1:0]  pos_v = '0;
  logic [2:0]  sign_v = '0;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  check_message_generator_if #(.DATA_W(32), .IDX_W(2)) m_if ();

  check_message_generator #(.DATA_W(32), .NUM_EDGES(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .min        (min_v),
    .second_min (smin_v),
    .pos        (pos_v),
    .sign_in    (sign_v),
    .m_if       (m_if),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One line per message transaction, then the individual comparisons.
  task automatic chk_msg(input string tag, input logic [1:0] idx, input logic [31:0] m);
    $display("msg   %-14s idx=%0d msg=%08h valid=%0b ready=%0b", tag,
             m_if.msg_idx, m_if.msg, m_if.msg_valid, m_if.msg_ready);
    chk({tag, "_valid"}, {31'd0, m_if.msg_valid}, 32'd1);
    chk({tag, "_idx"},   {30'd0, m_if.msg_idx},   {30'd0, idx});
    chk({tag, "_msg"},   m_if.msg,                m);
    chk({tag, "_busy"},  {31'd0, busy},           32'd1);
  endtask

  task automatic chk_quiet(input string tag, input logic exp_done);
    $display("quiet %-14s valid=%0b busy=%0b done=%0b", tag, m_if.msg_valid, busy, done);
    chk({tag, "_valid"}, {31'd0, m_if.msg_valid}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy},           32'd0);
    chk({tag, "_done"},  {31'd0, done},           {31'd0, exp_done});
  endtask

  task automatic chk_zero_bus(input string tag);
    chk({tag, "_msg0"}, m_if.msg,                32'd0);
    chk({tag, "_idx0"}, {30'd0, m_if.msg_idx},   32'd0);
  endtask

  task automatic launch(input logic [31:0] mn, input logic [31:0] sm,
                        input logic [1:0] p, input logic [2:0] s);
    min_v  = mn;
    smin_v = sm;
    pos_v  = p;
    sign_v = s;
    start  = 1'b1;
    $display("start min=%08h smin=%08h pos=%0d sign=%03b", mn, sm, p, s);
    tick();
    start = 1'b0;
  endtask

  initial begin
    m_if.msg_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk_quiet("reset", 1'b0);
    chk_zero_bus("reset");
    reset = 1'b0;
    tick();

    // Basic: p = 1; edge1 holds the minimum position -> second_min
    launch(32'h3F000000, 32'h3F800000, 2'd1, 3'b010);
    chk_msg("basic0", 2'd0, 32'hBF000000);
    tick();
    chk_msg("basic1", 2'd1, 32'h3F800000);
    tick();
    chk_msg("basic2", 2'd2, 32'hBF000000);
    tick();
    chk_quiet("basic_done", 1'b1);
    tick();
    chk_quiet("basic_after", 1'b0);

    // Backpressure during idx 1
    launch(32'h3F000000, 32'h3F800000, 2'd1, 3'b010);
    chk_msg("bp0", 2'd0, 32'hBF000000);
    tick();
    m_if.msg_ready = 1'b0;
    chk_msg("bp1_hold_a", 2'd1, 32'h3F800000);
    tick();
    chk_msg("bp1_hold_b", 2'd1, 32'h3F800000);
    tick();
    chk_msg("bp1_hold_c", 2'd1, 32'h3F800000);
    m_if.msg_ready = 1'b1;
    tick();
    chk_msg("bp2", 2'd2, 32'hBF000000);
    tick();
    chk_quiet("bp_done", 1'b1);
    tick();

    // Sign parity: all incoming negative, input sign of second_min ignored
    launch(32'h40000000, 32'hC0400000, 2'd0, 3'b111);
    chk_msg("par0", 2'd0, 32'h40400000);
    tick();
    chk_msg("par1", 2'd1, 32'h40000000);
    tick();
    chk_msg("par2", 2'd2, 32'h40000000);
    tick();
    chk_quiet("par_done", 1'b1);
    tick();

    // Out-of-range pos: every edge carries min
    launch(32'h3F800000, 32'h40000000, 2'd3, 3'b000);
    chk_msg("pos3_0", 2'd0, 32'h3F800000);
    tick();
    chk_msg("pos3_1", 2'd1, 32'h3F800000);
    tick();
    chk_msg("pos3_2", 2'd2, 32'h3F800000);
    tick();
    chk_quiet("pos3_done", 1'b1);
    tick();

    // Start while busy: second request during idx 0 is ignored
    launch(32'h3F000000, 32'h3F800000, 2'd1, 3'b010);
    min_v  = 32'h41000000;
    smin_v = 32'h42000000;
    pos_v  = 2'd0;
    sign_v = 3'b001;
    start  = 1'b1;
    chk_msg("busy0", 2'd0, 32'hBF000000);
    tick();
    start = 1'b0;
    chk_msg("busy1", 2'd1, 32'h3F800000);
    tick();
    chk_msg("busy2", 2'd2, 32'hBF000000);
    tick();
    chk_quiet("busy_done", 1'b1);
    tick();

    // Reset mid-operation while idx 1 is pending
    launch(32'h3F000000, 32'h3F800000, 2'd1, 3'b010);
    chk_msg("rst0", 2'd0, 32'hBF000000);
    tick();
    m_if.msg_ready = 1'b0;
    chk_msg("rst1_pend", 2'd1, 32'h3F800000);
    reset = 1'b1;
    tick();
    chk_quiet("rst_mid", 1'b0);
    chk_zero_bus("rst_mid");
    reset = 1'b0;
    m_if.msg_ready = 1'b1;
    tick();
    chk_quiet("rst_idle", 1'b0);

    // Fresh start after reset produces a full, correct sequence
    launch(32'h40000000, 32'hC0400000, 2'd0, 3'b111);
    chk_msg("fresh0", 2'd0, 32'h40400000);
    tick();
    chk_msg("fresh1", 2'd1, 32'h40000000);
    tick();
    chk_msg("fresh2", 2'd2, 32'h40000000);
    tick();
    chk_quiet("fresh_done", 1'b1);
    tick();

    // Start in the same cycle as reset: reset wins
    reset = 1'b1;
    launch(32'h3F000000, 32'h3F800000, 2'd1, 3'b010);
    chk_quiet("rst_start", 1'b0);
    chk_zero_bus("rst_start");
    reset = 1'b0;
    tick();
    chk_quiet("rst_start_after", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
